alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_types.sv | 47 ++++
 rtl/alu_behavioural.sv | 67 ++++++
 rtl/shifter.sv | 45 ++++
 rtl/alu.sv | 117 +++++++++++
 tb/tb_alu.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/alu_types.sv
// ---------------------------------------------------------------------------
// alu_types: shared types for the ALU slice.
//   alu_control_t    - 4-bit operation select seen on the alu control port
//   shift_mode_t     - mode select for the barrel shifter
//   SHAMT_W          - width of the shift amount taken from b
//   alu_control_name - mnemonic string for an operation (for benches/logs)
// ---------------------------------------------------------------------------
package alu_types;

    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0001,
        ALU_OR   = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_ADD  = 4'b1000,
        ALU_SUB  = 4'b1100,
        ALU_SLT  = 4'b1101,
        ALU_SLTU = 4'b1111
    } alu_control_t;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2
    } shift_mode_t;

    function automatic string alu_control_name(alu_control_t control);
        case (control)
            ALU_AND:  return "AND";
            ALU_OR:   return "OR";
            ALU_XOR:  return "XOR";
            ALU_SLL:  return "SLL";
            ALU_SRL:  return "SRL";
            ALU_SRA:  return "SRA";
            ALU_ADD:  return "ADD";
            ALU_SUB:  return "SUB";
            ALU_SLT:  return "SLT";
            ALU_SLTU: return "SLTU";
            default:  return "UNDEF";
        endcase
    endfunction

endpackage

// File: rtl/alu_behavioural.sv
// ---------------------------------------------------------------------------
// alu_behavioural: golden reference for alu, written with plain operators.
//   clk      in   unused (no state)
//   rst      in   forces result=0, overflow=0, equal=0, zero=1 while high
//   a, b     in   N-bit operands; b[4:0] is the shift amount
//   control  in   alu_control_t operation select
//   result   out  N-bit result; overflow/zero/equal flags as in alu
// ---------------------------------------------------------------------------
module alu_behavioural
    import alu_types::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_control_t control,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         zero,
    output logic         equal
);

    logic unused_clk;
    assign unused_clk = clk;

    logic [N-1:0] r;
    logic         v;

    always_comb begin
        r = '0;
        v = 1'b0;
        case (control)
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << b[SHAMT_W-1:0];
            ALU_SRL:  r = a >> b[SHAMT_W-1:0];
            ALU_SRA:  r = $signed(a) >>> b[SHAMT_W-1:0];
            ALU_ADD: begin
                r = a + b;
                v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
            end
            ALU_SUB: begin
                r = a - b;
                v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            ALU_SLT:  r = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {{(N-1){1'b0}}, (a < b)};
            default:  r = '0;
        endcase

        if (rst) begin
            result   = '0;
            overflow = 1'b0;
            zero     = 1'b1;
            equal    = 1'b0;
        end else begin
            result   = r;
            overflow = v;
            zero     = (r == '0);
            equal    = (a == b);
        end
    end

endmodule

// File: rtl/shifter.sv
// ---------------------------------------------------------------------------
// shifter: N-bit logarithmic barrel shifter.
//   data   in  N        value to shift
//   amount in  SHAMT_W  shift distance
//   mode   in  shift_mode_t  SLL (zero fill), SRL (zero fill), SRA (sign fill)
//   result out N        shifted value
// Left shifts reuse the right-shift stages by bit-reversing in and out.
// ---------------------------------------------------------------------------
module shifter
    import alu_types::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]       data,
    input  logic [SHAMT_W-1:0] amount,
    input  shift_mode_t        mode,
    output logic [N-1:0]       result
);

    function automatic logic [N-1:0] reverse_bits(logic [N-1:0] value);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = value[N-1-i];
        end
        return r;
    endfunction

    logic [N-1:0] stage;
    logic         fill;

    // NOTE: blocking assignments here are intentional -- each stage reads
    // the value the previous stage just produced within the same evaluation.
    always_comb begin
        fill  = (mode == SHIFT_SRA) && data[N-1];
        stage = (mode == SHIFT_SLL) ? reverse_bits(data) : data;
        for (int s = 0; s < SHAMT_W; s++) begin
            if (amount[s]) begin
                stage = (stage >> (1 << s))
                      | (fill ? ~({N{1'b1}} >> (1 << s)) : '0);
            end
        end
        result = (mode == SHIFT_SLL) ? reverse_bits(stage) : stage;
    end

endmodule

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu: structural, purely combinational ALU.
//   clk      in   system clock (no datapath state uses it)
//   rst      in   async active-high; forces result=0, overflow=0, equal=0,
//                 zero=1 while asserted, with no clock edge involved
//   a, b     in   N-bit operands; b[4:0] is the shift amount
//   control  in   alu_control_t operation select
//   result   out  N-bit result (0 for undefined encodings)
//   overflow out  signed overflow of ADD/SUB, 0 otherwise
//   zero     out  result == 0
//   equal    out  a == b, independent of control
// ADD, SUB, SLT and SLTU share one adder; comparisons come from the
// subtraction's sign, overflow and carry.
// ---------------------------------------------------------------------------
module alu
    import alu_types::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_control_t control,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         zero,
    output logic         equal
);

    logic unused_clk;
    assign unused_clk = clk;

    // Shared adder/subtractor: a + (b ^ sub) + sub.
    logic         sub_en;
    logic [N-1:0] b_operand;
    logic [N:0]   sum_full;
    logic [N-1:0] sum;
    logic         carry_out;
    logic         add_ovf;
    logic         less_signed;
    logic         less_unsigned;

    assign sub_en    = (control == ALU_SUB) || (control == ALU_SLT) || (control == ALU_SLTU);
    assign b_operand = b ^ {N{sub_en}};
    assign sum_full  = {1'b0, a} + {1'b0, b_operand} + {{N{1'b0}}, sub_en};
    assign sum       = sum_full[N-1:0];
    assign carry_out = sum_full[N];

    // Using the inverted b for subtraction makes one formula cover both
    // the ADD and SUB overflow conditions.
    assign add_ovf       = (a[N-1] == b_operand[N-1]) && (sum[N-1] != a[N-1]);
    // Sign of a-b is wrong exactly when the subtraction overflowed.
    assign less_signed   = sum[N-1] ^ add_ovf;
    // No carry out of a + ~b + 1 means a borrow, i.e. a < b unsigned.
    assign less_unsigned = ~carry_out;

    shift_mode_t  shift_mode;
    logic [N-1:0] shift_result;

    always_comb begin
        case (control)
            ALU_SLL: shift_mode = SHIFT_SLL;
            ALU_SRA: shift_mode = SHIFT_SRA;
            default: shift_mode = SHIFT_SRL;
        endcase
    end

    shifter #(.N(N)) u_shifter (
        .data   (a),
        .amount (b[SHAMT_W-1:0]),
        .mode   (shift_mode),
        .result (shift_result)
    );

    logic [N-1:0] result_raw;
    logic         overflow_raw;

    // NOTE: every output of this block gets a default before the case, so
    // undefined encodings cannot leave a value held and infer a latch.
    always_comb begin
        result_raw   = '0;
        overflow_raw = 1'b0;
        case (control)
            ALU_AND:  result_raw = a & b;
            ALU_OR:   result_raw = a | b;
            ALU_XOR:  result_raw = a ^ b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  result_raw = shift_result;
            ALU_ADD,
            ALU_SUB: begin
                result_raw   = sum;
                overflow_raw = add_ovf;
            end
            ALU_SLT:  result_raw = {{(N-1){1'b0}}, less_signed};
            ALU_SLTU: result_raw = {{(N-1){1'b0}}, less_unsigned};
            default:  result_raw = '0;
        endcase
    end

    // Reset overrides the outputs combinationally; there is no state to clear.
    always_comb begin
        if (rst) begin
            result   = '0;
            overflow = 1'b0;
            zero     = 1'b1;
            equal    = 1'b0;
        end else begin
            result   = result_raw;
            overflow = overflow_raw;
            zero     = (result_raw == '0);
            equal    = (a == b);
        end
    end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu: self-checking bench for alu. Directed vectors with hand-computed
// expectations, reset behaviour, then a corner cross-product and random
// pairs compared against alu_behavioural.
// ---------------------------------------------------------------------------
module tb_alu;
    import alu_types::*;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic [N-1:0] a;
    logic [N-1:0] b;
    alu_control_t control;

    logic [N-1:0] result,   g_result;
    logic         overflow, g_overflow;
    logic         zero,     g_zero;
    logic         equal,    g_equal;

    int checks   = 0;
    int failures = 0;

    alu #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .control  (control),
        .result   (result),
        .overflow (overflow),
        .zero     (zero),
        .equal    (equal)
    );

    alu_behavioural #(.N(N)) gold (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .control  (control),
        .result   (g_result),
        .overflow (g_overflow),
        .zero     (g_zero),
        .equal    (g_equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    typedef struct {
        alu_control_t ctrl;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  res;
        logic         ovf;
        logic         zr;
        logic         eq;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    localparam int NCORNER = 24;
    logic [31:0] corners [NCORNER];

    task automatic apply(input alu_control_t c, input logic [31:0] va,
                         input logic [31:0] vb);
        control = c;
        a       = va;
        b       = vb;
        #1;
    endtask

    task automatic compare_golden(input string tag);
        check({tag, " result"},   result,          g_result);
        check({tag, " overflow"}, {31'b0, overflow}, {31'b0, g_overflow});
        check({tag, " zero"},     {31'b0, zero},     {31'b0, g_zero});
        check({tag, " equal"},    {31'b0, equal},    {31'b0, g_equal});
    endtask

    initial begin
        vecs = '{
            '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0},
            '{ALU_SUB,  32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b1, 1'b1},
            '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0},
            '{ALU_SRA,  32'h80000000, 32'h00000021, 32'hC0000000, 1'b0, 1'b0, 1'b0},
            '{ALU_SRL,  32'h80000000, 32'h00000021, 32'h40000000, 1'b0, 1'b0, 1'b0},
            '{ALU_SLL,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1'b0},
            '{ALU_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0},
            '{ALU_SLTU, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0},
            '{ALU_SLT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0},
            '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0},
            '{ALU_OR,   32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0},
            '{ALU_XOR,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 1'b0, 1'b1, 1'b1},
            '{alu_control_t'(4'b0000), 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1'b1, 1'b0},
            '{alu_control_t'(4'b1110), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b1},
            '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0},
            '{ALU_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0},
            '{ALU_SUB,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b0},
            '{ALU_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0},
            '{ALU_SRA,  32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 1'b0, 1'b0, 1'b0},
            '{ALU_SLL,  32'h12345678, 32'hFFFFFFE4, 32'h23456780, 1'b0, 1'b0, 1'b0},
            '{ALU_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1}
        };
        corners = '{
            32'h00000000, 32'h00000001, 32'h00000002, 32'hFFFFFFFF,
            32'hFFFFFFFE, 32'h7FFFFFFF, 32'h7FFFFFFE, 32'h80000000,
            32'h80000001, 32'h55555555, 32'hAAAAAAAA, 32'h0000001F,
            32'h00000020, 32'h00000021, 32'h0000FFFF, 32'hFFFF0000,
            32'h12345678, 32'h87654321, 32'h40000000, 32'hC0000000,
            32'h3FFFFFFF, 32'h00008000, 32'h7FFF8000, 32'hDEADBEEF
        };

        // Reset state: equal must be forced low even with a == b.
        rst = 1'b1;
        apply(ALU_ADD, 32'h00000005, 32'h00000005);
        check("reset result",   result,            32'h0);
        check("reset overflow", {31'b0, overflow}, 32'h0);
        check("reset zero",     {31'b0, zero},     32'h1);
        check("reset equal",    {31'b0, equal},    32'h0);
        rst = 1'b0;
        #1;
        check("post-reset result", result,         32'h0000000A);
        check("post-reset equal",  {31'b0, equal}, 32'h1);

        // Directed vectors.
        for (int i = 0; i < NVEC; i++) begin
            string tag;
            apply(vecs[i].ctrl, vecs[i].a, vecs[i].b);
            tag = $sformatf("vec%0d %s", i, alu_control_name(vecs[i].ctrl));
            check({tag, " result"},   result,            vecs[i].res);
            check({tag, " overflow"}, {31'b0, overflow}, {31'b0, vecs[i].ovf});
            check({tag, " zero"},     {31'b0, zero},     {31'b0, vecs[i].zr});
            check({tag, " equal"},    {31'b0, equal},    {31'b0, vecs[i].eq});
        end

        // Mid-stream reset with ADD 1+1.
        apply(ALU_ADD, 32'h00000001, 32'h00000001);
        check("pre-rst add result", result, 32'h00000002);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid-rst result", result,         32'h0);
        check("mid-rst zero",   {31'b0, zero},  32'h1);
        check("mid-rst equal",  {31'b0, equal}, 32'h0);
        rst = 1'b0;
        #1;
        check("rst-release result", result, 32'h00000002);

        // Corner cross-product and random pairs for every encoding.
        for (int op = 0; op < 16; op++) begin
            for (int i = 0; i < NCORNER; i++) begin
                for (int j = 0; j < NCORNER; j++) begin
                    apply(alu_control_t'(op[3:0]), corners[i], corners[j]);
                    compare_golden($sformatf("gold op=%0h a=%h b=%h", op, corners[i], corners[j]));
                end
            end
            for (int k = 0; k < 25; k++) begin
                logic [31:0] ra;
                logic [31:0] rb;
                ra = $urandom();
                rb = $urandom();
                apply(alu_control_t'(op[3:0]), ra, rb);
                compare_golden($sformatf("rand op=%0h a=%h b=%h", op, ra, rb));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
